// File: rtl/weight_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module  : weight_loader_pkg
// Brief   : Shared array geometry defaults and loader FSM state encoding.
// Revision: 1.0 - initial release
// ============================================================================
package weight_loader_pkg;

   localparam int c_arraywidth  = 4;
   localparam int c_arrayheight = 4;
   localparam int c_datasize    = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/weight_loader.sv
`default_nettype none
// ============================================================================
// Module  : weight_loader
// Brief   : Streams weight rows from the weight buffer into the systolic
//           array's top PE row, zero-padding unused slots.
// Revision: 1.0 - initial release
// ============================================================================
module weight_loader
   import weight_loader_pkg::*;
#(
   parameter int ARRAYWIDTH  = c_arraywidth,
   parameter int ARRAYHEIGHT = c_arrayheight,
   parameter int DATASIZE    = c_datasize
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   input  logic [$clog2(ARRAYHEIGHT):0]     rows,
   output logic                             buf_rd_en,
   input  logic [ARRAYWIDTH*DATASIZE-1:0]   buf_weight,
   output logic                             write_weight_en,
   output logic [ARRAYWIDTH*DATASIZE-1:0]   array_weight,
   output logic                             busy,
   output logic                             done,
   output logic [7:0]                       load_cnt
);

   localparam int c_rw = $clog2(ARRAYHEIGHT) + 1;
   localparam logic [c_rw-1:0] c_height = c_rw'(ARRAYHEIGHT);
   localparam logic [c_rw-1:0] c_last   = c_rw'(ARRAYHEIGHT - 1);
   localparam logic [c_rw-1:0] c_one    = c_rw'(1);

   state_t            r_state;
   logic [c_rw-1:0]   r_k;
   logic [c_rw-1:0]   r_rows_q;
   logic              r_v1;
   logic              r_real1;
   logic [c_rw-1:0]   w_rows_clamped;

   assign w_rows_clamped = (rows > c_height) ? c_height : rows;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= ST_IDLE;
         r_k             <= '0;
         r_rows_q        <= '0;
         r_v1            <= 1'b0;
         r_real1         <= 1'b0;
         buf_rd_en       <= 1'b0;
         write_weight_en <= 1'b0;
         array_weight    <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         load_cnt        <= 8'd0;
      end else begin
         // Stage 1 marks a slot issued last cycle; stage 2 writes the row
         // returned by the buffer, or zero for a pad slot.
         r_v1            <= (r_state == ST_SHIFT);
         r_real1         <= buf_rd_en;
         write_weight_en <= r_v1;
         array_weight    <= (r_v1 && r_real1) ? buf_weight : '0;
         done            <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state   <= ST_SHIFT;
                  r_k       <= '0;
                  r_rows_q  <= w_rows_clamped;
                  buf_rd_en <= (w_rows_clamped != '0);
                  busy      <= 1'b1;
               end
            end
            ST_SHIFT: begin
               if (r_k == c_last) begin
                  r_state   <= ST_DRAIN;
                  r_k       <= '0;
                  buf_rd_en <= 1'b0;
               end else begin
                  r_k       <= r_k + c_one;
                  buf_rd_en <= ((r_k + c_one) < r_rows_q);
               end
            end
            ST_DRAIN: begin
               if (r_k == c_one) begin
                  r_state  <= ST_DONE;
                  r_k      <= '0;
                  done     <= 1'b1;
                  load_cnt <= load_cnt + 8'd1;
               end else begin
                  r_k <= r_k + c_one;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               busy    <= 1'b0;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
